serial_nbit_subtractor: RTL
===========================

SERIAL_NBIT_SUBTRACTOR -- requirements
Module: serial_nbit_subtractor

Interface
REQ-001 SHALL have parameter: N, default 8, operand/result width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 SHALL have port: X  input  N  minuend; sampled only on the edge where start is accepted.
REQ-006 SHALL have port: Y  input  N  subtrahend; sampled with X.
REQ-007 SHALL have port: bin  input  1  borrow-in; sampled with X.
REQ-008 SHALL have port: D  output  N  difference, registered.
REQ-009 SHALL have port: bout  output  1  borrow-out, registered.
REQ-010 SHALL have port: busy  output  1  high while a subtraction is in progress.
REQ-011 SHALL have port: done  output  1  single-cycle completion pulse.

Function
REQ-012 SHALL compute D = (X - Y - bin) mod 2^N; bout = 1 iff X < Y + bin (unsigned).
REQ-013 SHALL process one bit per cycle, LSB first: d_i = x_i ^ y_i ^ b_i; b_(i+1) = (~x_i & y_i) | (~(x_i ^ y_i) & b_i); b_0 = bin.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 SHALL accept start in IDLE or DONE: on that edge latch X, Y, bin into internal shift registers, clear bit counter to 0, go to RUN.
REQ-016 SHALL stay in RUN exactly N edges, incrementing the bit counter each edge; on the Nth RUN edge load D and bout from the completed result and go to DONE.
REQ-017 SHALL, in DONE, assert done for exactly one cycle; next edge goes to IDLE, or to RUN if start is high (back-to-back, no idle cycle).
REQ-018 SHALL drive busy high exactly when state is RUN; done and busy never high together.
REQ-019 SHALL ignore start while in RUN; operands latched at acceptance are unaffected by later X/Y/bin changes.
REQ-020 SHALL hold D and bout stable from one completion until the next completion; they do not change during RUN.
REQ-021 SHALL give latency: start accepted at edge k -> D/bout valid and done high in the cycle after edge k+N.
REQ-022 SHALL keep the bit counter width ceil(log2(N+1)) and never wrap within one operation.

Reset
REQ-023 SHALL, on rst_n low, immediately (asynchronously) force state IDLE, D = 0, bout = 0, busy = 0, done = 0, counter and shift registers 0.
REQ-024 SHALL abort an in-progress operation on reset without producing done; first start after rst_n rises is handled normally.

Configuration
REQ-025 SHALL, when macro SUB_OVERFLOW_EN is defined, add output port ovf (1 bit, registered, reset 0) = signed two's-complement overflow of X - Y - bin (b_N ^ b_(N-1)), updated together with D.
REQ-026 SHALL, when SUB_OVERFLOW_EN is undefined, have no ovf port and no overflow logic; all other behaviour identical.

Verification
REQ-027 SHALL cover, N=8: X=0x05, Y=0x03, bin=0, start 1 cycle -> busy 8 cycles, done pulse, D=0x02, bout=0.
REQ-028 SHALL cover: X=0x00, Y=0x01, bin=0 -> D=0xFF, bout=1; X=0xFF, Y=0xFF, bin=1 -> D=0xFF, bout=1.
REQ-029 SHALL cover with SUB_OVERFLOW_EN: X=0x80, Y=0x01, bin=0 -> D=0x7F, bout=0, ovf=1; X=0x7F, Y=0x01 -> D=0x7E, ovf=0.
REQ-030 SHALL cover: start held high continuously with operand changes during RUN -> each result reflects operands at acceptance, done every 9 cycles, no idle gap.
REQ-031 SHALL cover: rst_n pulsed low at RUN bit 4 -> outputs 0 immediately, no done; next operation X=0x10, Y=0x01 -> D=0x0F, bout=0.

Source files
------------

// File: rtl/serial_nbit_subtractor.sv
// Bit-serial N-bit subtractor: one difference bit per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_nbit_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         bin,
    output logic [N-1:0] D,
`ifdef SUB_OVERFLOW_EN
    output logic         ovf,
`endif
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           b_q, b_d;
    logic           bout_q, bout_d;
`ifdef SUB_OVERFLOW_EN
    logic           ovf_q, ovf_d;
`endif

    logic xi, yi, di, bn, last;

    assign xi   = x_q[0];
    assign yi   = y_q[0];
    assign di   = xi ^ yi ^ b_q;
    assign bn   = (~xi & yi) | (~(xi ^ yi) & b_q);
    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        bout_d  = bout_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = X;
                    y_d     = Y;
                    b_d     = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                b_d   = bn;
                // difference bits enter at the MSB and drift down to bit 0
                r_d   = {di, r_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    d_d     = {di, r_q[N-1:1]};
                    bout_d  = bn;
`ifdef SUB_OVERFLOW_EN
                    ovf_d   = bn ^ b_q;
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            b_q     <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            bout_q  <= bout_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign D    = d_q;
    assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
